// File: rtl/operand_entry_pkg.sv
// Shared constants and state encoding for the keypad operand accumulator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package operand_entry_pkg;

  localparam int NUM_W      = 25;
  localparam int MAX_DIGITS = 7;

  // dot_pos value shown when no decimal point has been typed
  localparam logic [3:0] DOT_NONE = 4'd10;

  localparam logic [4:0] KEY_DOT   = 5'd10;
  localparam logic [4:0] KEY_NEG   = 5'd11;
  localparam logic [4:0] KEY_BKSP  = 5'd12;
  localparam logic [4:0] KEY_ENTER = 5'd13;

  typedef enum logic [1:0] {
    ST_INT  = 2'd0,
    ST_FRAC = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [4:0] k);
    return k <= 5'd9;
  endfunction

endpackage

// File: rtl/operand_entry_div10.sv
// Restoring divide-by-10 of an NUM_W-bit unsigned value, one quotient bit per cycle.
// Latency: done is high in the NUM_W-th cycle after start, with quotient valid alongside it.
// Backpressure: none; start is only issued when idle, abort drops any divide in flight.
module div10_seq
  import operand_entry_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] dividend,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int STEP_W = $clog2(NUM_W + 1);
  localparam logic [STEP_W-1:0] STEPS = STEP_W'(NUM_W);

  logic              busy;
  logic [STEP_W-1:0] steps;
  logic [NUM_W-1:0]  q;
  logic [3:0]        rem;

  logic [4:0]        shifted;
  logic [4:0]        diff;
  logic              ge;
  logic [3:0]        rem_nxt;
  logic [NUM_W-1:0]  q_nxt;

  // One restoring step: bring in the next dividend bit, subtract 10 when it fits.
  always_comb begin
    shifted = {rem, q[NUM_W-1]};
    diff    = shifted - 5'd10;
    ge      = (shifted >= 5'd10);
    rem_nxt = ge ? diff[3:0] : shifted[3:0];
    q_nxt   = {q[NUM_W-2:0], ge};
  end

  // The last step's result is presented combinationally so the caller can take it on the same edge.
  assign done     = busy && (steps == STEP_W'(1));
  assign quotient = q_nxt;

  // Iteration state: dividend shifts out of q as quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      steps <= '0;
      q     <= '0;
      rem   <= '0;
    end else if (abort) begin
      busy  <= 1'b0;
      steps <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      steps <= STEPS;
      q     <= dividend;
      rem   <= '0;
    end else if (busy) begin
      q     <= q_nxt;
      rem   <= rem_nxt;
      steps <= steps - STEP_W'(1);
      if (steps == STEP_W'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Builds a display operand (value, digit count, sign, decimal point) from decoded keypad keys.
// Latency: outputs update the cycle after a key is accepted; backspace takes NUM_W cycles.
// Backpressure: ready drops during a backspace divide; keys offered while ready is low are dropped.
module operand_entry
  import operand_entry_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  output logic             ready,
  output logic [NUM_W-1:0] num,
  output logic [2:0]       num_length,
  output logic             sign,
  output logic [3:0]       dot_pos,
  output logic             mode,
  output logic             operand_valid,
  output logic             entry_err
);

  state_t           state, state_n, ret_state, ret_n;
  logic [2:0]       cnt, cnt_n;
  logic [2:0]       frac, frac_n;
  logic [NUM_W-1:0] num_n;
  logic             sign_n, mode_n;
  logic [3:0]       dp_n;
  logic             ov_n, err_n;

  logic             acc;
  logic             div_start;
  logic             div_done;
  logic [NUM_W-1:0] div_q;
  logic [NUM_W-1:0] digit;

  assign ready      = (state != ST_BUSY);
  assign acc        = key_valid && ready && !clear;
  assign digit      = NUM_W'(key_code[3:0]);
  assign num_length = (cnt == 3'd0) ? 3'd1 : cnt;

  div10_seq u_div10 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (clear),
    .dividend (num),
    .done     (div_done),
    .quotient (div_q)
  );

  // Next-state and next-operand decode for the accepted key or a finishing divide.
  always_comb begin
    state_n   = state;
    ret_n     = ret_state;
    num_n     = num;
    cnt_n     = cnt;
    frac_n    = frac;
    sign_n    = sign;
    dp_n      = dot_pos;
    mode_n    = mode;
    ov_n      = 1'b0;
    err_n     = 1'b0;
    div_start = 1'b0;

    if (acc) begin
      // After ENTER, a new digit or dot starts a fresh operand before being applied.
      if (state == ST_DONE && (is_digit(key_code) || key_code == KEY_DOT)) begin
        state_n = ST_INT;
        num_n   = '0;
        cnt_n   = 3'd0;
        frac_n  = 3'd0;
        sign_n  = 1'b0;
        dp_n    = DOT_NONE;
        mode_n  = 1'b0;
      end

      if (is_digit(key_code)) begin
        if (cnt_n == 3'(MAX_DIGITS)) begin
          err_n = 1'b1;
        end else if (!(state_n == ST_INT && cnt_n == 3'd0 && key_code == 5'd0)) begin
          num_n = (num_n << 3) + (num_n << 1) + digit;
          cnt_n = cnt_n + 3'd1;
          if (state_n == ST_FRAC) begin
            frac_n = frac_n + 3'd1;
            dp_n   = {1'b0, frac_n};
          end
        end
      end else begin
        case (key_code)
          KEY_DOT: begin
            if (state_n == ST_FRAC) begin
              err_n = 1'b1;
            end else begin
              state_n = ST_FRAC;
              mode_n  = 1'b1;
              dp_n    = 4'd0;
              // A bare dot reads as "0." so it occupies one display digit.
              if (cnt_n == 3'd0) begin
                cnt_n = 3'd1;
              end
            end
          end
          KEY_NEG: begin
            sign_n = ~sign;
          end
          KEY_BKSP: begin
            if (state == ST_FRAC && frac == 3'd0) begin
              state_n = ST_INT;
              mode_n  = 1'b0;
              dp_n    = DOT_NONE;
            end else if (state != ST_DONE && cnt != 3'd0) begin
              state_n   = ST_BUSY;
              ret_n     = state;
              div_start = 1'b1;
            end
          end
          KEY_ENTER: begin
            ov_n    = 1'b1;
            state_n = ST_DONE;
          end
          default: begin
          end
        endcase
      end
    end else if (state == ST_BUSY && div_done) begin
      num_n   = div_q;
      state_n = ret_state;
      if (ret_state == ST_FRAC) begin
        frac_n = frac - 3'd1;
        dp_n   = {1'b0, frac_n};
        cnt_n  = (cnt <= 3'd1) ? 3'd1 : cnt - 3'd1;
      end else begin
        cnt_n = cnt - 3'd1;
      end
    end
  end

  // State and operand registers; clear wins over any key in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_INT;
      ret_state     <= ST_INT;
      num           <= '0;
      cnt           <= 3'd0;
      frac          <= 3'd0;
      sign          <= 1'b0;
      dot_pos       <= DOT_NONE;
      mode          <= 1'b0;
      operand_valid <= 1'b0;
      entry_err     <= 1'b0;
    end else if (clear) begin
      state         <= ST_INT;
      ret_state     <= ST_INT;
      num           <= '0;
      cnt           <= 3'd0;
      frac          <= 3'd0;
      sign          <= 1'b0;
      dot_pos       <= DOT_NONE;
      mode          <= 1'b0;
      operand_valid <= 1'b0;
      entry_err     <= 1'b0;
    end else begin
      state         <= state_n;
      ret_state     <= ret_n;
      num           <= num_n;
      cnt           <= cnt_n;
      frac          <= frac_n;
      sign          <= sign_n;
      dot_pos       <= dp_n;
      mode          <= mode_n;
      operand_valid <= ov_n;
      entry_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a scoreboard of expected operand snapshots.
// Latency: checks pulses one cycle after accept, operand fields once ready returns.
// Backpressure: waits on ready with a bounded cycle budget.
module tb_operand_entry;
  import operand_entry_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             key_valid = 1'b0;
  logic [4:0]       key_code = 5'd0;
  logic             ready;
  logic [NUM_W-1:0] num;
  logic [2:0]       num_length;
  logic             sign;
  logic [3:0]       dot_pos;
  logic             mode;
  logic             operand_valid;
  logic             entry_err;

  operand_entry dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .ready         (ready),
    .num           (num),
    .num_length    (num_length),
    .sign          (sign),
    .dot_pos       (dot_pos),
    .mode          (mode),
    .operand_valid (operand_valid),
    .entry_err     (entry_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic [2:0]  len;
    logic        sign;
    logic [3:0]  dp;
    logic        mode;
    logic        ov;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ov_cnt = 0;

  always @(posedge clk) if (operand_valid === 1'b1) ov_cnt <= ov_cnt + 1;

  function automatic exp_t mk(input int n, input int len, input logic s,
                              input int dp, input logic m, input logic ov, input logic err);
    exp_t e;
    e.num = 32'(n); e.len = 3'(len); e.sign = s; e.dp = 4'(dp);
    e.mode = m; e.ov = ov; e.err = err;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic send_key(input logic [4:0] k);
    wait_ready();
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  task automatic step(input string tag, input logic [4:0] k, input exp_t e);
    exp_t x;
    sb.push_back(e);
    send_key(k);
    x = sb.pop_front();
    chk({tag, ".ov"},  32'(operand_valid), 32'(x.ov));
    chk({tag, ".err"}, 32'(entry_err),     32'(x.err));
    wait_ready();
    chk({tag, ".num"},  32'(num),        x.num);
    chk({tag, ".len"},  32'(num_length), 32'(x.len));
    chk({tag, ".sign"}, 32'(sign),       32'(x.sign));
    chk({tag, ".dp"},   32'(dot_pos),    32'(x.dp));
    chk({tag, ".mode"}, 32'(mode),       32'(x.mode));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".num"},   32'(num),           32'd0);
    chk({tag, ".len"},   32'(num_length),    32'd1);
    chk({tag, ".sign"},  32'(sign),          32'd0);
    chk({tag, ".dp"},    32'(dot_pos),       32'd10);
    chk({tag, ".mode"},  32'(mode),          32'd0);
    chk({tag, ".ready"}, 32'(ready),         32'd1);
    chk({tag, ".ov"},    32'(operand_valid), 32'd0);
    chk({tag, ".err"},   32'(entry_err),     32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int busy_n;
    int ov_base;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1,2,DOT,3,4,ENTER -> 12.34 entered
    ov_base = ov_cnt;
    step("t1.k1",  5'd1,      mk(1,    1, 0, 10, 0, 0, 0));
    step("t1.k2",  5'd2,      mk(12,   2, 0, 10, 0, 0, 0));
    step("t1.dot", KEY_DOT,   mk(12,   2, 0, 0,  1, 0, 0));
    step("t1.dot2",KEY_DOT,   mk(12,   2, 0, 0,  1, 0, 1));
    step("t1.k3",  5'd3,      mk(123,  3, 0, 1,  1, 0, 0));
    step("t1.k4",  5'd4,      mk(1234, 4, 0, 2,  1, 0, 0));
    step("t1.ent", KEY_ENTER, mk(1234, 4, 0, 2,  1, 1, 0));
    @(posedge clk); #1;
    chk("t1.ov_low", 32'(operand_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1.ov_pulses", 32'(ov_cnt - ov_base), 32'd1);

    // Leading zeros suppressed, then digit-limit rejection
    do_clear();
    step("t2.z1", 5'd0, mk(0, 1, 0, 10, 0, 0, 0));
    step("t2.z2", 5'd0, mk(0, 1, 0, 10, 0, 0, 0));
    step("t2.k7", 5'd7, mk(7, 1, 0, 10, 0, 0, 0));
    do_clear();
    e = 0;
    for (int i = 1; i <= 7; i++) begin
      e = e * 10 + 9;
      step("t2.nine", 5'd9, mk(e, i, 0, 10, 0, 0, 0));
    end
    step("t2.over", 5'd9, mk(9999999, 7, 0, 10, 0, 0, 1));

    // Backspace in integer part: ready low for the full divide, keys dropped meanwhile
    do_clear();
    step("t3.k4", 5'd4, mk(4,   1, 0, 10, 0, 0, 0));
    step("t3.k5", 5'd5, mk(45,  2, 0, 10, 0, 0, 0));
    step("t3.k6", 5'd6, mk(456, 3, 0, 10, 0, 0, 0));
    send_key(KEY_BKSP);
    busy_n    = 0;
    key_valid = 1'b1;
    key_code  = 5'd9;
    while (ready !== 1'b1 && busy_n < 100) begin
      busy_n++;
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    key_code  = 5'd0;
    chk("t3.busy_cycles", 32'(busy_n), 32'd25);
    chk("t3.num", 32'(num), 32'd45);
    chk("t3.len", 32'(num_length), 32'd2);
    @(posedge clk); #1;
    chk("t3.num_hold", 32'(num), 32'd45);

    // Backspace through the fractional part and then the dot
    do_clear();
    step("t4.dot", KEY_DOT,  mk(0, 1, 0, 0,  1, 0, 0));
    step("t4.k5",  5'd5,     mk(5, 2, 0, 1,  1, 0, 0));
    step("t4.bs1", KEY_BKSP, mk(0, 1, 0, 0,  1, 0, 0));
    step("t4.bs2", KEY_BKSP, mk(0, 1, 0, 10, 0, 0, 0));

    // Sign toggle, ENTER, and a new digit restarting the entry
    do_clear();
    step("t5.k3",  5'd3,      mk(3, 1, 0, 10, 0, 0, 0));
    step("t5.neg", KEY_NEG,   mk(3, 1, 1, 10, 0, 0, 0));
    step("t5.ent", KEY_ENTER, mk(3, 1, 1, 10, 0, 1, 0));
    step("t5.bs",  KEY_BKSP,  mk(3, 1, 1, 10, 0, 0, 0));
    step("t5.k9",  5'd9,      mk(9, 1, 0, 10, 0, 0, 0));
    clear     = 1'b1;
    key_valid = 1'b1;
    key_code  = 5'd5;
    @(posedge clk); #1;
    clear     = 1'b0;
    key_valid = 1'b0;
    key_code  = 5'd0;
    chk_reset_vals("t5.clr");
    @(posedge clk); #1;
    chk("t5.clr_hold", 32'(num), 32'd0);

    // Asynchronous reset in the middle of a divide
    do_clear();
    step("t6.k4", 5'd4, mk(4,  1, 0, 10, 0, 0, 0));
    step("t6.k5", 5'd5, mk(45, 2, 0, 10, 0, 0, 0));
    send_key(KEY_BKSP);
    chk("t6.busy", 32'(ready), 32'd0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6.arst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("t6.ready", 32'(ready), 32'd1);
    chk("t6.num_idle", 32'(num), 32'd0);
    step("t6.k3", 5'd3, mk(3, 1, 0, 10, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
